// File: rtl/adc_window_capture.sv
// Serial multi-lane ADC deserialiser with a circular frame history that freezes
// a pre/post window around a trigger edge and drains it as a ready/valid stream.
module adc_window_capture #(
   parameter int DATA_WIDTH   = 12,
   parameter int NUM_CHANNELS = 16,
   parameter int PRE_SAMPLES  = 16,
   parameter int POST_SAMPLES = 48,
   localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CHANNELS-1:0] adc_data_in,
   input  logic                    adc_frame_clk,
   input  logic                    arm,
   input  logic                    trigger_capture,
   input  logic                    abort,
   output logic [DATA_WIDTH-1:0]   m_data,
   output logic [CH_W-1:0]         m_chan,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    m_last,
   output logic                    busy,
   output logic                    capture_done,
   output logic                    frame_err
);

   localparam int DEPTH = PRE_SAMPLES + POST_SAMPLES;
   localparam int AW    = $clog2(DEPTH);
   localparam int FW    = NUM_CHANNELS * DATA_WIDTH;
   localparam int TOTAL = DEPTH * NUM_CHANNELS;
   localparam int BW    = $clog2(TOTAL) + 1;
   localparam int BCW   = $clog2(DATA_WIDTH + 1);
   localparam int PW    = $clog2(PRE_SAMPLES + 1);
   localparam int QW    = $clog2(POST_SAMPLES + 1);

   generate
      if ((DEPTH & (DEPTH - 1)) != 0 || PRE_SAMPLES < 1 || POST_SAMPLES < 1) begin : g_bad_params
         $error("adc_window_capture: PRE_SAMPLES+POST_SAMPLES must be a power of two, both >= 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_ARMED,
      ST_POST,
      ST_READOUT,
      ST_DONE
   } state_t;

   // ---------------------------------------------------------------------
   // Deserialiser
   // ---------------------------------------------------------------------
   logic [BCW-1:0]        bit_cnt_reg;
   logic [DATA_WIDTH-1:0] shift_reg [NUM_CHANNELS];
   logic [FW-1:0]         frame_packed;
   logic [FW-1:0]         frame_data_reg;
   logic                  frame_strobe_reg;
   logic                  frame_err_reg;
   logic                  word_full;
   logic                  short_frame;

   assign word_full   = (bit_cnt_reg == BCW'(DATA_WIDTH));
   assign short_frame = adc_frame_clk && (bit_cnt_reg != '0) && !word_full;

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt_reg <= '0;
      end else if (adc_frame_clk) begin
         bit_cnt_reg <= BCW'(1);
      end else if (bit_cnt_reg == '0 || word_full) begin
         // Unaligned, or a complete word not followed by a pulse: wait for the next pulse.
         bit_cnt_reg <= '0;
      end else begin
         bit_cnt_reg <= bit_cnt_reg + BCW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            shift_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            shift_reg[i] <= {shift_reg[i][DATA_WIDTH-2:0], adc_data_in[i]};
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_pack
         assign frame_packed[gi*DATA_WIDTH +: DATA_WIDTH] = shift_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_strobe_reg <= 1'b0;
         frame_data_reg   <= '0;
      end else begin
         frame_strobe_reg <= word_full;
         if (word_full) begin
            frame_data_reg <= frame_packed;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   state_t          state_reg, state_next;
   logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]   trig_ptr_reg, trig_ptr_next;
   logic [PW-1:0]   fill_cnt_reg, fill_cnt_next;
   logic [QW-1:0]   post_cnt_reg, post_cnt_next;
   logic            trig_prev_reg;
   logic [BW-1:0]   ld_beat_reg, ld_beat_next;
   logic [CH_W-1:0] ld_chan_reg, ld_chan_next;
   logic [AW-1:0]   ld_frame_reg, ld_frame_next;

   logic            trig_edge;
   logic            wr_en;
   logic            arm_go;
   logic            beat_take;
   logic            ld_en;
   logic            m_valid_reg;
   logic            m_last_reg;
   logic [DATA_WIDTH-1:0] m_data_reg;
   logic [CH_W-1:0]       m_chan_reg;

   assign trig_edge = trigger_capture && !trig_prev_reg;
   assign wr_en     = frame_strobe_reg &&
                      (state_reg == ST_FILL || state_reg == ST_ARMED || state_reg == ST_POST);
   assign arm_go    = (state_reg == ST_IDLE) && arm && !abort;
   assign beat_take = m_valid_reg && m_ready;
   assign ld_en     = (state_reg == ST_READOUT) && (ld_beat_reg != BW'(TOTAL)) &&
                      (!m_valid_reg || m_ready);

   always_comb begin
      state_next    = state_reg;
      wr_ptr_next   = wr_ptr_reg;
      trig_ptr_next = trig_ptr_reg;
      fill_cnt_next = fill_cnt_reg;
      post_cnt_next = post_cnt_reg;
      ld_beat_next  = ld_beat_reg;
      ld_chan_next  = ld_chan_reg;
      ld_frame_next = ld_frame_reg;

      if (wr_en) begin
         wr_ptr_next = wr_ptr_reg + AW'(1);
      end

      case (state_reg)
         ST_IDLE: begin
            if (arm) begin
               state_next    = ST_FILL;
               wr_ptr_next   = '0;
               fill_cnt_next = '0;
            end
         end
         ST_FILL: begin
            if (wr_en) begin
               fill_cnt_next = fill_cnt_reg + PW'(1);
               if (fill_cnt_reg == PW'(PRE_SAMPLES - 1)) begin
                  state_next = ST_ARMED;
               end
            end
         end
         ST_ARMED: begin
            // A frame written in this same cycle still belongs to the pre-trigger history.
            if (trig_edge) begin
               state_next    = ST_POST;
               trig_ptr_next = wr_ptr_next;
               post_cnt_next = '0;
            end
         end
         ST_POST: begin
            if (wr_en) begin
               post_cnt_next = post_cnt_reg + QW'(1);
               if (post_cnt_reg == QW'(POST_SAMPLES - 1)) begin
                  state_next = ST_READOUT;
               end
            end
         end
         ST_READOUT: begin
            if (beat_take && m_last_reg) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (state_reg != ST_READOUT) begin
         ld_beat_next  = '0;
         ld_chan_next  = '0;
         ld_frame_next = '0;
      end else if (ld_en) begin
         ld_beat_next = ld_beat_reg + BW'(1);
         if (ld_chan_reg == CH_W'(NUM_CHANNELS - 1)) begin
            ld_chan_next  = '0;
            ld_frame_next = ld_frame_reg + AW'(1);
         end else begin
            ld_chan_next = ld_chan_reg + CH_W'(1);
         end
      end

      if (abort) begin
         state_next = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         wr_ptr_reg    <= '0;
         trig_ptr_reg  <= '0;
         fill_cnt_reg  <= '0;
         post_cnt_reg  <= '0;
         trig_prev_reg <= 1'b0;
         ld_beat_reg   <= '0;
         ld_chan_reg   <= '0;
         ld_frame_reg  <= '0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         wr_ptr_reg    <= wr_ptr_next;
         trig_ptr_reg  <= trig_ptr_next;
         fill_cnt_reg  <= fill_cnt_next;
         post_cnt_reg  <= post_cnt_next;
         trig_prev_reg <= trigger_capture;
         ld_beat_reg   <= ld_beat_next;
         ld_chan_reg   <= ld_chan_next;
         ld_frame_reg  <= ld_frame_next;
         if (short_frame) begin
            frame_err_reg <= 1'b1;
         end else if (arm_go) begin
            frame_err_reg <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Frame history RAM; read address tracks the frame of the next beat to load
   // ---------------------------------------------------------------------
   logic [FW-1:0]         frame_mem [DEPTH];
   logic [FW-1:0]         rd_data_reg;
   logic [AW-1:0]         rd_addr;
   logic [DATA_WIDTH-1:0] rd_words [NUM_CHANNELS];

   assign rd_addr = trig_ptr_reg - AW'(PRE_SAMPLES) + ld_frame_next;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         frame_mem[wr_ptr_reg] <= frame_data_reg;
      end
      rd_data_reg <= frame_mem[rd_addr];
   end

   generate
      for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_unpack
         assign rd_words[gi] = rd_data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Stream output register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid_reg <= 1'b0;
         m_last_reg  <= 1'b0;
         m_data_reg  <= '0;
         m_chan_reg  <= '0;
      end else if (abort) begin
         m_valid_reg <= 1'b0;
         m_last_reg  <= 1'b0;
      end else if (ld_en) begin
         m_valid_reg <= 1'b1;
         m_last_reg  <= (ld_beat_reg == BW'(TOTAL - 1));
         m_data_reg  <= rd_words[ld_chan_reg];
         m_chan_reg  <= ld_chan_reg;
      end else if (beat_take) begin
         m_valid_reg <= 1'b0;
         m_last_reg  <= 1'b0;
      end
   end

   assign m_data       = m_data_reg;
   assign m_chan       = m_chan_reg;
   assign m_valid      = m_valid_reg;
   assign m_last       = m_last_reg;
   assign busy         = (state_reg != ST_IDLE);
   assign capture_done = (state_reg == ST_DONE);
   assign frame_err    = frame_err_reg;

endmodule

// File: tb/tb_adc_window_capture.sv
// Directed bench for adc_window_capture: a free-running ramp serialiser feeds the
// lanes and every readout is compared beat by beat against the list of words sent.
module tb_adc_window_capture;

   localparam int DW    = 12;
   localparam int NCH   = 16;
   localparam int PRE   = 16;
   localparam int POST  = 48;
   localparam int TOTAL = (PRE + POST) * NCH;
   localparam int CHW   = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [NCH-1:0] adc_data_in;
   logic           adc_frame_clk;
   logic           arm;
   logic           trigger_capture;
   logic           abort;
   logic [DW-1:0]  m_data;
   logic [CHW-1:0] m_chan;
   logic           m_valid;
   logic           m_ready;
   logic           m_last;
   logic           busy;
   logic           capture_done;
   logic           frame_err;

   adc_window_capture #(
      .DATA_WIDTH   (DW),
      .NUM_CHANNELS (NCH),
      .PRE_SAMPLES  (PRE),
      .POST_SAMPLES (POST)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .adc_data_in     (adc_data_in),
      .adc_frame_clk   (adc_frame_clk),
      .arm             (arm),
      .trigger_capture (trigger_capture),
      .abort           (abort),
      .m_data          (m_data),
      .m_chan          (m_chan),
      .m_valid         (m_valid),
      .m_ready         (m_ready),
      .m_last          (m_last),
      .busy            (busy),
      .capture_done    (capture_done),
      .frame_err       (frame_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int word_n = 0, bit_idx = 0, cur_n = 0, cur_bit = 0, dropped_n = -1;
   int trig_n = 0;
   bit glitch_req = 1'b0;
   int sent_q[$];

   function automatic logic [DW-1:0] lane_word(input int ch, input int n);
      int v;
      v = (ch << 8) + n;
      return v[DW-1:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Ramp serialiser: lane ch sends (ch<<8)+n, MSB first, pulse on the MSB.
   initial begin
      logic [DW-1:0] w;
      adc_data_in   = '0;
      adc_frame_clk = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (glitch_req && bit_idx == 7) begin
            glitch_req = 1'b0;
            dropped_n  = word_n;
            bit_idx    = 0;
            word_n++;
         end
         cur_n = word_n;
         cur_bit = bit_idx;
         adc_frame_clk = (bit_idx == 0);
         for (int ch = 0; ch < NCH; ch++) begin
            w = lane_word(ch, word_n);
            adc_data_in[ch] = w[DW-1-bit_idx];
         end
         bit_idx++;
         if (bit_idx == DW) begin
            sent_q.push_back(word_n);
            bit_idx = 0;
            word_n++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_word(input int n, input int b);
      int cyc;
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!(cur_n == n && cur_bit == b) && cyc < 20000);
      if (cyc >= 20000) chk("wait_word_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_arm(output int n0);
      tick();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      n0 = cur_n;
      chk("busy_after_arm", {31'd0, busy}, 32'd1);
   endtask

   task automatic do_trigger(input int t, input int b);
      wait_word(t, b);
      trigger_capture = 1'b1;
      trig_n = t;
      tick();
      tick();
      trigger_capture = 1'b0;
   endtask

   // Consume the stream; stop after stop_after beats or after the m_last beat.
   task automatic run_readout(input int stop_after, input int ready_pct);
      int k, tidx, f, ch, n;
      bit stalled, got_last, done;
      logic [31:0] held, obs, e;
      logic [3:0] chv;
      k = 0; tidx = -1; stalled = 0; got_last = 0; done = 0; held = '0;
      for (int cyc = 0; cyc < 12000; cyc++) begin
         tick();
         obs = {14'd0, m_valid, m_last, m_chan, m_data};
         if (got_last) begin
            m_ready = 1'b0;
            chk("capture_done_pulse", {30'd0, capture_done, m_valid}, 32'b10);
            tick();
            chk("done_to_idle", {30'd0, busy, capture_done}, 32'd0);
            done = 1;
            break;
         end
         if (stalled) chk("stall_hold", obs, held);
         if (k == stop_after) begin
            m_ready = 1'b0;
            done = 1;
            break;
         end
         m_ready = ($urandom_range(99) < ready_pct);
         stalled = 0;
         if (m_valid) begin
            if (m_ready) begin
               if (tidx < 0) begin
                  for (int i = sent_q.size() - 1; i >= 0; i--) begin
                     if (sent_q[i] == trig_n) begin
                        tidx = i;
                        break;
                     end
                  end
                  if (tidx < PRE) begin
                     chk("trigger_word_known", 32'd0, 32'd1);
                     m_ready = 1'b0;
                     return;
                  end
               end
               f = k / NCH;
               ch = k % NCH;
               n = sent_q[tidx - PRE + f];
               chv = ch[3:0];
               e = {14'd0, 1'b1, (k == TOTAL - 1), chv, lane_word(ch, n)};
               chk("beat", obs, e);
               if (k == TOTAL - 1) chk("done_not_early", {31'd0, capture_done}, 32'd0);
               if (m_last) got_last = 1;
               k++;
            end else begin
               stalled = 1;
               held = obs;
            end
         end
      end
      if (!done) chk("readout_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int n0;
      reset = 1'b1; arm = 1'b0; trigger_capture = 1'b0; abort = 1'b0; m_ready = 1'b0;
      repeat (3) tick();
      arm = 1'b1;
      tick();
      chk("reset_flags", {27'd0, m_valid, m_last, busy, capture_done, frame_err}, 32'd0);
      chk("reset_data", {16'd0, 4'd0, m_chan, m_data}, 32'd0);
      arm = 1'b0;
      reset = 1'b0;
      tick();
      chk("idle_after_reset", {31'd0, busy}, 32'd0);

      // Ramp capture, trigger coincident with a frame strobe
      do_arm(n0);
      do_trigger(n0 + 20, 1);
      run_readout(TOTAL, 100);

      // Long ARMED period: history wraps many times
      do_arm(n0);
      do_trigger(n0 + PRE + 200, 6);
      run_readout(TOTAL, 100);

      // Backpressure
      do_arm(n0);
      do_trigger(n0 + 30, 1);
      run_readout(TOTAL, 30);

      // Trigger while filling is ignored
      do_arm(n0);
      wait_word(n0 + 5, 3);
      trigger_capture = 1'b1;
      tick();
      tick();
      trigger_capture = 1'b0;
      wait_word(n0 + 70, 0);
      chk("fill_trigger_ignored", {30'd0, busy, m_valid}, 32'b10);
      do_trigger(n0 + 72, 1);
      run_readout(TOTAL, 100);

      // Short frame: word dropped, sticky error, arm clears it
      do_arm(n0);
      wait_word(n0 + 20, 0);
      chk("frame_err_clean", {31'd0, frame_err}, 32'd0);
      glitch_req = 1'b1;
      for (int i = 0; i < 100 && glitch_req; i++) tick();
      wait_word(dropped_n + 3, 0);
      chk("frame_err_set", {31'd0, frame_err}, 32'd1);
      do_trigger(dropped_n + 5, 6);
      run_readout(TOTAL, 100);
      chk("frame_err_sticky", {31'd0, frame_err}, 32'd1);
      do_arm(n0);
      chk("frame_err_cleared", {31'd0, frame_err}, 32'd0);

      // Abort mid-readout, then a clean capture
      do_trigger(n0 + 20, 1);
      run_readout(300, 100);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_stops", {30'd0, m_valid, busy}, 32'd0);
      do_arm(n0);
      do_trigger(n0 + 20, 1);
      run_readout(TOTAL, 100);

      // Reset mid-readout, then a clean capture
      do_arm(n0);
      do_trigger(n0 + 20, 1);
      run_readout(300, 100);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("reset_stops", {29'd0, m_valid, busy, frame_err}, 32'd0);
      do_arm(n0);
      do_trigger(n0 + 20, 1);
      run_readout(TOTAL, 100);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
